pdm_mic_deserializer: RTL
=========================

// Module: pdm_mic_deserializer
// PURPOSE
//  Drives the PDM microphone clock and consumes the resynchronised 1-bit PDM stream produced by
//  the input FlipFlop stage. Counts ones over a fixed decimation window and emits one unsigned
//  PCM sample per window. Output uses a valid/ready handshake toward the record-buffer writer.
//  Sits between the mic-data flop and the sample memory controller.
// PARAMETERS
//  CLK_DIV  50   clk cycles per m_clk half-period (100 MHz clk -> 1 MHz m_clk); legal >= 2
//  DECIM    128  PDM bits per PCM sample; legal >= 2
//  OUT_W    8    pcm_data width; must satisfy 2**OUT_W > DECIM
// PORTS
//  clk        in   1      system clock; all logic on posedge
//  reset      in   1      asynchronous, active-low reset
//  en         in   1      record enable; 1 = run mic clock and produce samples
//  pdm_in     in   1      PDM data bit, already synchronised to clk by the upstream FlipFlop
//  m_clk      out  1      microphone clock, 50% duty, period 2*CLK_DIV clk cycles
//  pcm_data   out  OUT_W  ones-count of the last completed window (0..DECIM)
//  pcm_valid  out  1      pcm_data holds an unconsumed sample
//  pcm_ready  in   1      downstream accepts pcm_data when pcm_valid & pcm_ready
//  overrun    out  1      sticky: a sample was overwritten before it was accepted
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; m_clk, pcm_data, pcm_valid, overrun, all counters = 0.
//  States: IDLE -> RUN when en=1 (sampled on clk). RUN -> IDLE on the first clk with en=0.
//   Entering RUN clears overrun and starts div_cnt, bit_cnt, ones_cnt at 0.
//  IDLE: m_clk held 0, counters held 0. A pending sample (pcm_valid=1) is kept until accepted.
//  RUN, clock divider: div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1, div_cnt wraps to 0 and m_clk toggles.
//  Sample tick: cycle with div_cnt==CLK_DIV-1 and m_clk==0 (the cycle before m_clk rises).
//   pdm_in is captured only on that cycle. First tick is cycle CLK_DIV-1 of RUN. Ticks then repeat
//   every 2*CLK_DIV cycles.
//  Accumulate: on each tick, ones_cnt += pdm_in and bit_cnt++. On the tick with bit_cnt==DECIM-1:
//   - pcm_data <= ones_cnt + pdm_in
//   - pcm_valid <= 1 on the next clk
//   - bit_cnt and ones_cnt <= 0
//  Latency: pcm_valid rises 1 clk after the DECIM-th tick of the window.
//  Width rule: ones_cnt width = OUT_W. Count cannot exceed DECIM, so no saturation logic.
//  Handshake: transfer occurs on a clk with pcm_valid & pcm_ready. pcm_valid then drops next clk,
//   unless a new sample loads in that same cycle. pcm_data is stable while pcm_valid=1 and no
//   new sample loads.
//  Simultaneous transfer and new sample: new sample loads, pcm_valid stays 1, overrun unchanged.
//  New sample with pcm_valid=1 and pcm_ready=0: new value overwrites pcm_data, pcm_valid stays 1,
//   overrun <= 1. overrun stays set until reset or the next IDLE->RUN.
//  en falls mid-window: partial window discarded, no pcm_valid from it. m_clk is 0 the next clk.
//  reset mid-window: immediate clear of all state. No sample is emitted for the partial window.
// TESTING  (CLK_DIV=2, DECIM=8, OUT_W=4 unless stated)
//  1. en=1, pdm_in=1 constant -> m_clk period 4 clk. First pcm_valid 30 clk after RUN entry.
//     pcm_data=8 every 32 clk. pcm_ready=1 gives 1-clk valid pulses.
//  2. en=1, pdm_in=0 constant -> pcm_data=0 each window, overrun=0.
//  3. pdm_in toggled every sample tick (1,0,1,0...) -> pcm_data=4. Pattern 1,1,1,0 repeating -> pcm_data=6.
//  4. pdm_in=1, pcm_ready=0 across two windows -> pcm_valid held, overrun=1 after 2nd window,
//     pcm_data=8. Then ready=1 for 1 clk -> valid drops, overrun stays 1.
//     ready=1 exactly on the load cycle -> no overrun.
//  5. en=0 at the 4th tick of a window -> m_clk=0 next clk, no pcm_valid. en=1 again -> first
//     sample is a full fresh window (value 8 with pdm_in=1), overrun cleared.
//  6. reset pulsed low mid-window, asynchronous to clk -> m_clk, pcm_valid, pcm_data, overrun = 0
//     before the next clk edge. After release, behaviour matches test 1 timing.

Source files
------------

// File: rtl/pdm_mic_deserializer_if.sv
// PCM sample handshake between the PDM deserializer and the record-buffer writer.
interface pdm_mic_deserializer_if #(
   parameter int unsigned OUT_W = 8
);
   logic [OUT_W-1:0] pcm_data;
   logic             pcm_valid;
   logic             pcm_ready;

   modport master (output pcm_data, output pcm_valid, input pcm_ready);
   modport slave  (input pcm_data, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/pdm_mic_deserializer.sv
// PDM microphone front end: generates m_clk, counts ones per decimation window and
// presents one unsigned PCM sample per window over a valid/ready handshake.
module pdm_mic_deserializer #(
   parameter int unsigned CLK_DIV = 50,
   parameter int unsigned DECIM   = 128,
   parameter int unsigned OUT_W   = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          en,
   input  logic                          pdm_in,
   output logic                          m_clk,
   output logic                          overrun,
   pdm_mic_deserializer_if.master        pcm
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BIT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DECIM - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [DIV_W-1:0] div_cnt;
   logic [BIT_W-1:0] bit_cnt;
   logic [OUT_W-1:0] ones_cnt;

   logic             tick_c;
   logic             load_c;
   logic [OUT_W-1:0] ones_next_c;

   // Sample tick is the cycle before m_clk rises; a dropping en suppresses it.
   always_comb begin
      tick_c      = (state == RUN) && en && (div_cnt == DIV_LAST) && !m_clk;
      load_c      = tick_c && (bit_cnt == BIT_LAST);
      ones_next_c = ones_cnt + OUT_W'(pdm_in);
   end

   // State, clock divider, window accumulator and output sample register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         m_clk         <= 1'b0;
         div_cnt       <= '0;
         bit_cnt       <= '0;
         ones_cnt      <= '0;
         overrun       <= 1'b0;
         pcm.pcm_data  <= '0;
         pcm.pcm_valid <= 1'b0;
      end else begin
         // A new sample always wins; overrun only if the old one was not taken this cycle.
         if (load_c) begin
            pcm.pcm_data  <= ones_next_c;
            pcm.pcm_valid <= 1'b1;
            if (pcm.pcm_valid && !pcm.pcm_ready) begin
               overrun <= 1'b1;
            end
         end else if (pcm.pcm_valid && pcm.pcm_ready) begin
            pcm.pcm_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               m_clk    <= 1'b0;
               div_cnt  <= '0;
               bit_cnt  <= '0;
               ones_cnt <= '0;
               if (en) begin
                  state   <= RUN;
                  overrun <= 1'b0;
               end
            end
            RUN: begin
               if (!en) begin
                  // Partial window is dropped.
                  state    <= IDLE;
                  m_clk    <= 1'b0;
                  div_cnt  <= '0;
                  bit_cnt  <= '0;
                  ones_cnt <= '0;
               end else begin
                  if (div_cnt == DIV_LAST) begin
                     div_cnt <= '0;
                     m_clk   <= ~m_clk;
                  end else begin
                     div_cnt <= div_cnt + DIV_W'(1);
                  end
                  if (tick_c) begin
                     if (load_c) begin
                        bit_cnt  <= '0;
                        ones_cnt <= '0;
                     end else begin
                        bit_cnt  <= bit_cnt + BIT_W'(1);
                        ones_cnt <= ones_next_c;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
